ysyx_24100005_mem_arbiter: RTL

Shares one memory handshake port between the instruction fetch unit (IFU) and the load/store unit (LSU) of the multi-cycle core. It arbitrates, locks the port to one requester per transaction, forwards the request, and routes the response back to that requester only.

---
 rtl/ysyx_24100005_arb_pkg.sv | 20 ++
 rtl/ysyx_24100005_arb_pick.sv | 34 +++
 rtl/ysyx_24100005_mem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ysyx_24100005_arb_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states and owner IDs.
package ysyx_24100005_arb_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    // The requester that did not own the previous grant.
    function automatic logic other_owner(input logic owner);
        return (owner == OWNER_IFU) ? OWNER_LSU : OWNER_IFU;
    endfunction

endpackage

// File: rtl/ysyx_24100005_arb_pick.sv
// Combinational grant picker for the IFU/LSU arbiter.
// ARB_RR_EN selects round-robin on contention; otherwise the LSU has fixed priority.
module ysyx_24100005_arb_pick (
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic last_owner,
    output logic grant,
    output logic owner
);
    import ysyx_24100005_arb_pkg::*;

    always_comb begin
        grant = ifu_valid | lsu_valid;
        owner = OWNER_IFU;
`ifdef ARB_RR_EN
        if (ifu_valid && lsu_valid) begin
            owner = other_owner(last_owner);
        end else if (lsu_valid) begin
            owner = OWNER_LSU;
        end
`else
        if (lsu_valid) begin
            owner = OWNER_LSU;
        end
`endif
    end

`ifndef ARB_RR_EN
    // History is irrelevant under fixed priority.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Shares one memory handshake port between IFU and LSU, one locked transaction at a time.
// Define ARB_RR_EN for round-robin arbitration; default is fixed LSU-over-IFU priority.
module ysyx_24100005_mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_W-1:0]     ifu_req_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_W-1:0]     ifu_resp_rdata,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_W-1:0]     lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_W-1:0]     lsu_req_wdata,
    input  logic [DATA_W/8-1:0]   lsu_req_wmask,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_W-1:0]     lsu_resp_rdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [DATA_W-1:0]     mem_resp_rdata
);
    import ysyx_24100005_arb_pkg::*;

    localparam int unsigned MASK_W = DATA_W / 8;

    arb_state_t state;
    logic       owner;
    logic       last_owner;
    logic       pick_grant;
    logic       pick_owner;

    ysyx_24100005_arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_owner (last_owner),
        .grant      (pick_grant),
        .owner      (pick_owner)
    );

    // Grant is offered only in IDLE; responses are steered to the locked owner only in RESP.
    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        ifu_resp_rdata = '0;
        lsu_resp_rdata = '0;
        mem_resp_ready = 1'b0;

        if (state == IDLE && pick_grant) begin
            ifu_req_ready = (pick_owner == OWNER_IFU);
            lsu_req_ready = (pick_owner == OWNER_LSU);
        end

        if (state == RESP) begin
            if (owner == OWNER_LSU) begin
                lsu_resp_valid = mem_resp_valid;
                lsu_resp_rdata = mem_resp_rdata;
                mem_resp_ready = lsu_resp_ready;
            end else begin
                ifu_resp_valid = mem_resp_valid;
                ifu_resp_rdata = mem_resp_rdata;
                mem_resp_ready = ifu_resp_ready;
            end
        end
    end

    // Transaction FSM; the memory request fields are captured at grant and held until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner         <= OWNER_IFU;
            last_owner    <= OWNER_IFU;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_grant) begin
                        state         <= REQ;
                        owner         <= pick_owner;
                        last_owner    <= pick_owner;
                        mem_req_valid <= 1'b1;
                        if (pick_owner == OWNER_LSU) begin
                            mem_req_addr  <= lsu_req_addr;
                            mem_req_wen   <= lsu_req_wen;
                            mem_req_wdata <= lsu_req_wdata;
                            mem_req_wmask <= lsu_req_wmask;
                        end else begin
                            // Instruction fetches are always plain reads.
                            mem_req_addr  <= ifu_req_addr;
                            mem_req_wen   <= 1'b0;
                            mem_req_wdata <= DATA_W'(0);
                            mem_req_wmask <= MASK_W'(0);
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state         <= RESP;
                        mem_req_valid <= 1'b0;
                    end
                end
                RESP: begin
                    if (mem_resp_valid && mem_resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
